switch_debounce: RTL
====================

Name: switch_debounce

Overview:
- Upstream conditioning stage for the board's slide switches and push-buttons. Feeds the LED display/chaser logic with clean control signals.
- Each of CHANNELS raw asynchronous inputs is synchronised into CLK and debounced by a per-channel stability counter and state machine.
- Outputs per channel: a registered clean level, plus single-cycle rise and fall pulses. Downstream logic uses the pulses as step/direction strobes.

Parameters:
- CHANNELS, 4, number of independent switch inputs (1..16).
- COUNT_MAX, 1000000, consecutive synchronised samples required to accept a new level; 10 ms at 100 MHz. Legal range 2..2^24.
- Derived localparam CNT_W = $clog2(COUNT_MAX). The counter holds 0..COUNT_MAX-1.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- SW  input  CHANNELS  raw switch/button inputs, asynchronous to CLK.
- LEVEL  output  CHANNELS  debounced level, registered.
- RISE  output  CHANNELS  one-cycle pulse when LEVEL[i] goes 0->1, registered.
- FALL  output  CHANNELS  one-cycle pulse when LEVEL[i] goes 1->0, registered.

Behaviour:
- Reset (RST_N low, asynchronous assert): sync flops s1/s2 = 0, all states = STABLE_LOW, all counters = 0, LEVEL = 0, RISE = 0, FALL = 0.
- Reset release is synchronous to CLK by system convention. No pulses occur during reset.
- Synchroniser: two-flop chain per channel, SW[i] -> s1[i] -> s2[i]. The FSM sees only s2.
- Per-channel FSM, 2-bit state, four states:
  - STABLE_LOW: if s2=1, go to PEND_HIGH with cnt=0; else stay.
  - PEND_HIGH:
    - If s2=0 (bounce): return to STABLE_LOW, cnt=0, no pulse.
    - Else if cnt==COUNT_MAX-1: go to STABLE_HIGH, LEVEL=1, RISE=1 for that one cycle.
    - Else cnt=cnt+1.
  - STABLE_HIGH: if s2=0, go to PEND_LOW with cnt=0; else stay.
  - PEND_LOW: mirror of PEND_HIGH.
    - s2=1 returns to STABLE_HIGH with no pulse.
    - Commit sets LEVEL=0 and FALL=1.
- RISE and FALL default to 0 every cycle unless committed that cycle. RISE[i] and FALL[i] are never high together.
- Latency: edge 0 is the first CLK edge after a clean SW[i] transition. LEVEL and RISE/FALL become 1 at edge COUNT_MAX+2, i.e. the (COUNT_MAX+3)th edge.
- Rejection: any s2 reversal before commit restarts the count from the stable state. A pulse of COUNT_MAX or fewer samples at s2 never changes LEVEL.
- Channels are fully independent. Simultaneous commits on several channels each produce their own pulse in the same cycle.
- Counter never exceeds COUNT_MAX-1. It is held at 0 in the stable states, with no wrap-around.
- Reset mid-pending: the count is abandoned with no pulse.
- SW held high through reset release: the channel passes PEND_HIGH and emits one RISE after the normal latency. This is intentional, as downstream must see the initial state.
- Metastability on s1 is tolerated; only s2 is used.

Test Plan:
All scenarios use COUNT_MAX=4, CHANNELS=4.
- Reset check: hold RST_N=0 with SW=4'hF and toggling -> LEVEL=0, RISE=0, FALL=0 throughout. After release with SW=4'hF held -> LEVEL=4'hF at the 7th edge, RISE=4'hF for exactly 1 cycle.
- Clean press: SW[0] 0->1 held -> LEVEL[0]=1 at edge 6 (edges from 0), RISE[0] high only at that edge. Release -> FALL[0] pulse 6 edges after release, LEVEL[0]=0.
- Bounce: SW[1] toggles 1,0,1,0,1 every 2 cycles, then holds 1 -> no RISE during bouncing. Exactly one RISE[1], 6 edges after the final 0->1 edge.
- Short glitch: SW[2] high for 3 cycles then low -> LEVEL[2] stays 0, no RISE or FALL pulse.
- Simultaneous channels: SW[3:0] 0000->1111 on one edge -> RISE=4'hF in a single cycle. Then only SW[2] drops -> FALL=4'b0100 only.
- Async reset mid-pending: SW[0] rises, assert RST_N=0 two cycles into PEND_HIGH between clock edges -> outputs clear immediately. After release with SW[0] held -> a single RISE[0] at full latency.

Source files
------------

// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner: two-flop synchroniser, per-channel stability
// counter FSM, registered clean level plus single-cycle rise/fall strobes.
module switch_debounce #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned COUNT_MAX = 1000000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] SW,
  output logic [CHANNELS-1:0] LEVEL,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL
);

  localparam int unsigned CNT_W = $clog2(COUNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] PEND_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] PEND_LOW    = 2'd3;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [1:0]          state     [CHANNELS];
  logic [1:0]          state_nxt [CHANNELS];
  logic [CNT_W-1:0]    cnt       [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt   [CHANNELS];
  logic [CHANNELS-1:0] level_nxt;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  // Two-flop synchroniser; only s2 reaches the FSM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i] <= STABLE_LOW;
        cnt[i]   <= '0;
      end
      LEVEL <= '0;
      RISE  <= '0;
      FALL  <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      LEVEL <= level_nxt;
      RISE  <= rise_nxt;
      FALL  <= fall_nxt;
    end
  end

  // Next-state logic; counter is zero outside the pending states.
  always_comb begin
    level_nxt = LEVEL;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = '0;
      case (state[i])
        STABLE_LOW: begin
          if (s2[i]) state_nxt[i] = PEND_HIGH;
        end
        PEND_HIGH: begin
          if (!s2[i]) begin
            state_nxt[i] = STABLE_LOW;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = STABLE_HIGH;
            level_nxt[i] = 1'b1;
            rise_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i] = CNT_W'(cnt[i] + 1'b1);
          end
        end
        STABLE_HIGH: begin
          if (!s2[i]) state_nxt[i] = PEND_LOW;
        end
        PEND_LOW: begin
          if (s2[i]) begin
            state_nxt[i] = STABLE_HIGH;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = STABLE_LOW;
            level_nxt[i] = 1'b0;
            fall_nxt[i]  = 1'b1;
          end else begin
            cnt_nxt[i] = CNT_W'(cnt[i] + 1'b1);
          end
        end
        default: state_nxt[i] = STABLE_LOW;
      endcase
    end
  end

endmodule
